// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-period helper
// used by both the receive and transmit FIFO blocks.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side port bundle of the UART receive FIFO: read strobe, FWFT head,
// fill flags and the one-cycle error pulses.
interface uart_rx_fifo_if;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       frame_err;
  logic       overflow;

  modport master (output rd_en, input rd_data, empty, full, frame_err, overflow);
  modport slave  (input rd_en, output rd_data, empty, full, frame_err, overflow);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; flags and head update one clock after push/pop.
// A push while full is taken only together with a pop; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || rd_en_i);
  // Head reads as zero while empty so the output is defined out of reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT FIFO; a byte lands one clock after its stop sample.
// When full, a good byte is dropped with an overflow pulse unless a pop coincides.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_rxp,
  uart_rx_fifo_if.slave  rx
);
  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int TW   = $clog2(CPB + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CPB - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

  rx_state_t     state_q;
  logic [1:0]    sync_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          frame_err_q, overflow_q;
  logic          rx_s, bit_done, push, fifo_full;

  assign rx_s     = sync_q[1];
  assign bit_done = (tick_q == BIT_LAST);
  assign push     = (state_q == STOP) && bit_done && rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], i_rxp};
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      case (state_q)
        IDLE: if (!rx_s) begin
          bit_cnt_q <= '0;
          tick_q    <= '0;
          state_q   <= START;
        end
        START: if (tick_q == HALF_LAST) begin
          tick_q  <= '0;
          state_q <= rx_s ? IDLE : DATA;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
        DATA: if (bit_done) begin
          tick_q    <= '0;
          shift_q   <= {rx_s, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_q <= STOP;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
        STOP: if (bit_done) begin
          tick_q <= '0;
          if (rx_s) begin
            overflow_q <= fifo_full && !rx.rd_en;
            state_q    <= IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= BREAK;
          end
        end else begin
          tick_q <= tick_q + 1'b1;
        end
        // Hold here while the line stays low so a break is reported only once.
        BREAK: if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (shift_q),
    .rd_en_i   (rx.rd_en),
    .rd_data_o (rx.rd_data),
    .empty_o   (rx.empty),
    .full_o    (fifo_full)
  );

  assign rx.full      = fifo_full;
  assign rx.frame_err = frame_err_q;
  assign rx.overflow  = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table vectors, hand-written corner sequences and random
// frames scored against a queue model of the receive FIFO.
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 25_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int DEPTH    = 16;
  localparam int CPB      = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF     = CPB / 2;
  // Edges from driving the start bit to empty falling / error pulse visible.
  localparam int LAT      = HALF + 9 * CPB + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxp = 1'b1;
  always #20 clk = ~clk;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_rxp (rxp),
    .rx    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0, ov_cnt = 0, wide_cnt = 0;
  int exp_fe = 0, exp_ov = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0;
  logic [7:0] model_q [$];

  always @(negedge clk) begin
    if (bus.frame_err) fe_cnt++;
    if (bus.overflow) ov_cnt++;
    if ((bus.frame_err && fe_prev) || (bus.overflow && ov_prev)) wide_cnt++;
    fe_prev = bus.frame_err;
    ov_prev = bus.overflow;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    rxp = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxp = b[i];
      repeat (CPB) tick();
    end
    rxp = stopb;
    repeat (CPB) tick();
    rxp = 1'b1;
  endtask

  // Model update from the receive rules, then the frame itself.
  task automatic rx_frame(input logic [7:0] b, input logic stopb, input logic rd_at_stop);
    if (!stopb) exp_fe++;
    else begin
      if (rd_at_stop && model_q.size() > 0) void'(model_q.pop_front());
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else exp_ov++;
    end
    fork
      send_frame(b, stopb);
      if (rd_at_stop) begin
        repeat (LAT - 1) tick();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
      end
    join
  endtask

  task automatic pop_check(input string name);
    if (model_q.size() == 0) check({name, "_empty"}, bus.empty, 1);
    else begin
      check({name, "_vld"}, bus.empty, 0);
      check({name, "_dat"}, bus.rd_data, model_q[0]);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      void'(model_q.pop_front());
    end
  endtask

  task automatic drain_check(input string name);
    while (model_q.size() > 0) pop_check(name);
    check({name, "_drained"}, bus.empty, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_fe;
    logic       exp_push;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int k, fe0, ov0;
    logic [7:0] b;
    logic sb;

    tbl[0] = '{8'h55, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h81, 1'b0, 1'b1, 1'b0};
    bus.rd_en = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_fe", bus.frame_err, 0);
    check("rst_ov", bus.overflow, 0);
    check("rst_data", bus.rd_data, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Single byte with exact arrival latency
    k = 0;
    fork
      send_frame(8'h55, 1'b1);
      while (bus.empty && k < LAT + 20) begin tick(); k++; end
    join
    check("single_lat", k, LAT);
    check("single_dat", bus.rd_data, 8'h55);
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    check("single_popped", bus.empty, 1);
    repeat (4) tick();

    // Framing error pulse timing, then recovery
    k = 0;
    fe0 = fe_cnt;
    fork
      send_frame(8'hA5, 1'b0);
      while (!bus.frame_err && k < LAT + 20) begin tick(); k++; end
    join
    exp_fe++;
    check("fe_lat", k, LAT);
    check("fe_nopush", bus.empty, 1);
    check("fe_one", fe_cnt - fe0, 1);
    repeat (4) tick();
    rx_frame(8'h3C, 1'b1, 1'b0);
    pop_check("after_fe");

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      fe0 = fe_cnt;
      send_frame(tbl[i].data, tbl[i].stop_bit);
      repeat (4) tick();
      if (tbl[i].exp_fe) exp_fe++;
      check($sformatf("tbl%0d_fe", i), fe_cnt - fe0, tbl[i].exp_fe);
      check($sformatf("tbl%0d_empty", i), bus.empty, !tbl[i].exp_push);
      if (tbl[i].exp_push) begin
        check($sformatf("tbl%0d_dat", i), bus.rd_data, tbl[i].data);
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
      end
    end

    // Glitch shorter than half a bit
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rxp = 1'b0;
    repeat (HALF / 2) tick();
    rxp = 1'b1;
    repeat (2 * CPB) tick();
    check("glitch_empty", bus.empty, 1);
    check("glitch_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    rx_frame(8'h3C, 1'b1, 1'b0);
    pop_check("after_glitch");

    // Back-to-back frames
    rx_frame(8'h55, 1'b1, 1'b0);
    rx_frame(8'hAA, 1'b1, 1'b0);
    rx_frame(8'h12, 1'b1, 1'b0);
    rx_frame(8'h34, 1'b1, 1'b0);
    tick();
    check("b2b_full", bus.full, 0);
    check("b2b_count", model_q.size(), 4);
    drain_check("b2b");

    // Overflow, then a push coinciding with a pop while full
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) begin
      rx_frame(8'(i), 1'b1, 1'b0);
      if (i == 14) check("ovf_not_full", bus.full, 0);
    end
    check("ovf_full", bus.full, 1);
    rx_frame(8'h10, 1'b1, 1'b0);
    tick();
    check("ovf_pulse", ov_cnt - ov0, 1);
    drain_check("ovf_drain");
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) rx_frame(8'(i), 1'b1, 1'b0);
    rx_frame(8'h10, 1'b1, 1'b1);
    tick();
    check("ovf_rd_nopulse", ov_cnt - ov0, 0);
    check("ovf_rd_full", bus.full, 1);
    check("ovf_rd_head", bus.rd_data, 8'h01);
    drain_check("ovf_rd_drain");

    // Reset in the middle of data bit 4
    rx_frame(8'h77, 1'b1, 1'b0);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send_frame(8'hF5, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        model_q.delete();
      end
    join
    repeat (4) tick();
    check("rst_mid_empty", bus.empty, 1);
    check("rst_mid_full", bus.full, 0);
    check("rst_mid_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    rx_frame(8'hC3, 1'b1, 1'b0);
    check("rst_mid_next", bus.rd_data, 8'hC3);
    drain_check("rst_mid");

    // Random frames, random errors, random reads and gaps
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      rx_frame(b, sb, 1'b0);
      repeat ($urandom_range(0, 2)) pop_check("rnd");
      repeat (sb ? $urandom_range(0, 3) : 5) tick();
    end
    drain_check("rnd_end");

    tick();
    check("total_fe", fe_cnt, exp_fe);
    check("total_ov", ov_cnt, exp_ov);
    check("pulse_width", wide_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
